// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe game controller:
// cell, winner and reject codes, FSM states and the winning lines.
package ttt_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_X_TURN,
        S_O_TURN,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [1:0] REJ_RANGE    = 2'b01;
    localparam logic [1:0] REJ_OCCUPIED = 2'b10;

    // Rows, columns, then diagonals; entry 0 is the leftmost triple.
    localparam logic [0:7][0:2][3:0] LINES = {
        4'd1, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6,
        4'd7, 4'd8, 4'd9,
        4'd1, 4'd4, 4'd7,
        4'd2, 4'd5, 4'd8,
        4'd3, 4'd6, 4'd9,
        4'd1, 4'd5, 4'd9,
        4'd3, 4'd5, 4'd7
    };

    function automatic logic [1:0] cell_at(
        input logic [17:0] b,
        input logic [3:0]  c
    );
        cell_at = CELL_EMPTY;
        for (int k = 0; k < 9; k++) begin
            if (c == 4'(k + 1)) begin
                cell_at = b[2*k +: 2];
            end
        end
    endfunction

endpackage

// File: rtl/ttt_game_ctrl_if.sv
// Move request handshakes for both players.
// master drives the requests, slave (the controller) drives the readys.
interface ttt_game_ctrl_if;

    logic       x_valid;
    logic [3:0] x_cell;
    logic       x_ready;
    logic       o_valid;
    logic [3:0] o_cell;
    logic       o_ready;

    modport master (
        output x_valid, x_cell, o_valid, o_cell,
        input  x_ready, o_ready
    );

    modport slave (
        input  x_valid, x_cell, o_valid, o_cell,
        output x_ready, o_ready
    );

endinterface

// File: rtl/ttt_line_check.sv
// Combinational win detector: flags any of the 8 lines
// fully owned by the given player code.
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [17:0] board,
    input  logic [1:0]  player,
    output logic        win
);

    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (player != CELL_EMPTY &&
                cell_at(board, LINES[i][0]) == player &&
                cell_at(board, LINES[i][1]) == player &&
                cell_at(board, LINES[i][2]) == player) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: grants the on-turn player, validates
// and writes moves, checks for win/draw, and optionally forfeits idle turns.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TO_W           = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            first_player,
    ttt_game_ctrl_if.slave  moves,
    output logic [17:0]     board,
    output logic [1:0]      turn,
    output logic [1:0]      winner,
    output logic            game_over,
    output logic [3:0]      move_count,
    output logic            reject,
    output logic [1:0]      reject_code,
    output logic            timeout
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST =
        TO_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t          state, state_n;
    logic [17:0]     board_n;
    logic [1:0]      turn_n;
    logic [1:0]      winner_n;
    logic            over_n;
    logic [3:0]      count_n;
    logic            reject_n;
    logic [1:0]      rcode_n;
    logic            timeout_n;
    logic [1:0]      mover, mover_n;
    logic [TO_W-1:0] to_cnt, to_cnt_n;

    logic            hs;
    logic [3:0]      cur_cell;
    logic [1:0]      cur_code;
    logic            bad_range;
    logic            occupied;
    logic            win;

    assign moves.x_ready = (state == S_X_TURN) && !start;
    assign moves.o_ready = (state == S_O_TURN) && !start;

    assign hs = (moves.x_ready && moves.x_valid) ||
                (moves.o_ready && moves.o_valid);

    assign cur_cell  = (state == S_O_TURN) ? moves.o_cell : moves.x_cell;
    assign cur_code  = (state == S_O_TURN) ? CELL_O : CELL_X;
    assign bad_range = (cur_cell == 4'd0) || (cur_cell > 4'd9);
    assign occupied  = cell_at(board, cur_cell) != CELL_EMPTY;

    ttt_line_check u_line_check (
        .board  (board),
        .player (mover),
        .win    (win)
    );

    always_comb begin
        state_n   = state;
        board_n   = board;
        winner_n  = winner;
        count_n   = move_count;
        reject_n  = 1'b0;
        rcode_n   = reject_code;
        timeout_n = 1'b0;
        mover_n   = mover;
        to_cnt_n  = to_cnt;
        turn_n    = CELL_EMPTY;

        unique case (state)
            S_IDLE: begin
                to_cnt_n = '0;
            end
            S_X_TURN, S_O_TURN: begin
                if (hs) begin
                    to_cnt_n = '0;
                    if (bad_range) begin
                        reject_n = 1'b1;
                        rcode_n  = REJ_RANGE;
                    end else if (occupied) begin
                        reject_n = 1'b1;
                        rcode_n  = REJ_OCCUPIED;
                    end else begin
                        for (int k = 0; k < 9; k++) begin
                            if (cur_cell == 4'(k + 1)) begin
                                board_n[2*k +: 2] = cur_code;
                            end
                        end
                        count_n = move_count + 4'd1;
                        mover_n = cur_code;
                        state_n = S_CHECK;
                    end
                end else if (TO_EN && to_cnt == TO_LAST) begin
                    timeout_n = 1'b1;
                    to_cnt_n  = '0;
                    state_n   = (state == S_X_TURN) ? S_O_TURN : S_X_TURN;
                end else if (TO_EN) begin
                    to_cnt_n = to_cnt + TO_W'(1);
                end
            end
            S_CHECK: begin
                to_cnt_n = '0;
                if (win) begin
                    winner_n = mover;
                    state_n  = S_DONE;
                end else if (move_count == 4'd9) begin
                    winner_n = WIN_DRAW;
                    state_n  = S_DONE;
                end else begin
                    state_n = (mover == CELL_X) ? S_O_TURN : S_X_TURN;
                end
            end
            S_DONE: begin
                to_cnt_n = '0;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A restart overrides whatever the current state decided.
        if (start) begin
            state_n   = first_player ? S_O_TURN : S_X_TURN;
            board_n   = '0;
            count_n   = 4'd0;
            winner_n  = WIN_NONE;
            to_cnt_n  = '0;
            reject_n  = 1'b0;
            timeout_n = 1'b0;
        end

        if (state_n == S_X_TURN) begin
            turn_n = CELL_X;
        end else if (state_n == S_O_TURN) begin
            turn_n = CELL_O;
        end
        over_n = (state_n == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            board       <= '0;
            turn        <= CELL_EMPTY;
            winner      <= WIN_NONE;
            game_over   <= 1'b0;
            move_count  <= 4'd0;
            reject      <= 1'b0;
            reject_code <= 2'b00;
            timeout     <= 1'b0;
            mover       <= CELL_EMPTY;
            to_cnt      <= '0;
        end else begin
            state       <= state_n;
            board       <= board_n;
            turn        <= turn_n;
            winner      <= winner_n;
            game_over   <= over_n;
            move_count  <= count_n;
            reject      <= reject_n;
            reject_code <= rcode_n;
            timeout     <= timeout_n;
            mover       <= mover_n;
            to_cnt      <= to_cnt_n;
        end
    end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed games plus random
// play compared each cycle against a rule-level game model.
module tb_ttt_game_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        first_player;
    logic [17:0] board;
    logic [1:0]  turn;
    logic [1:0]  winner;
    logic        game_over;
    logic [3:0]  move_count;
    logic        reject;
    logic [1:0]  reject_code;
    logic        timeout;

    ttt_game_ctrl_if moves ();

    ttt_game_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .TO_W           (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .first_player (first_player),
        .moves        (moves),
        .board        (board),
        .turn         (turn),
        .winner       (winner),
        .game_over    (game_over),
        .move_count   (move_count),
        .reject       (reject),
        .reject_code  (reject_code),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the game in terms of the rules, not the FSM.
    int b [1:9];
    int m_cnt, m_win, m_whose, m_idle, m_rcode;
    bit m_on, m_chk, m_over, m_rej, m_tmo, armed;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit has_line(input int p);
        bit w = 0;
        for (int r = 0; r < 3; r++)
            if (b[3*r+1] == p && b[3*r+2] == p && b[3*r+3] == p) w = 1;
        for (int c = 1; c <= 3; c++)
            if (b[c] == p && b[c+3] == p && b[c+6] == p) w = 1;
        if (b[1] == p && b[5] == p && b[9] == p) w = 1;
        if (b[3] == p && b[5] == p && b[7] == p) w = 1;
        return w;
    endfunction

    function automatic logic [17:0] exp_board();
        int v = 0;
        for (int k = 1; k <= 9; k++) v += b[k] << (2 * (k - 1));
        return 18'(v);
    endfunction

    function automatic logic [1:0] exp_turn();
        return (m_on && !m_chk) ? 2'(m_whose + 1) : 2'b00;
    endfunction

    task automatic clear_board();
        for (int k = 1; k <= 9; k++) b[k] = 0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit fp,
                              input bit xv, input int xc,
                              input bit ov, input int oc);
        bit v;
        int c;
        m_rej = 0;
        m_tmo = 0;
        if (r) begin
            clear_board();
            m_cnt = 0; m_win = 0; m_on = 0; m_chk = 0; m_over = 0;
            m_whose = 0; m_idle = 0; m_rcode = 0; armed = 1;
        end else if (s) begin
            clear_board();
            m_cnt = 0; m_win = 0; m_on = 1; m_chk = 0; m_over = 0;
            m_whose = fp ? 1 : 0; m_idle = 0;
        end else if (m_chk) begin
            m_chk = 0;
            if (has_line(m_whose + 1)) begin
                m_win = m_whose + 1; m_over = 1; m_on = 0;
            end else if (m_cnt == 9) begin
                m_win = 3; m_over = 1; m_on = 0;
            end else begin
                m_whose = 1 - m_whose;
            end
        end else if (m_on) begin
            v = m_whose ? ov : xv;
            c = m_whose ? oc : xc;
            if (v) begin
                m_idle = 0;
                if (c < 1 || c > 9) begin
                    m_rej = 1; m_rcode = 1;
                end else if (b[c] != 0) begin
                    m_rej = 1; m_rcode = 2;
                end else begin
                    b[c] = m_whose + 1;
                    m_cnt++;
                    m_chk = 1;
                end
            end else if (TO != 0 && m_idle == TO - 1) begin
                m_tmo = 1;
                m_whose = 1 - m_whose;
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit s, input bit fp,
                         input int xc, input int oc);
        bit xv = (xc >= 0);
        bit ov = (oc >= 0);
        @(negedge clk);
        rst            = r;
        start          = s;
        first_player   = fp;
        moves.x_valid  = xv;
        moves.x_cell   = xv ? 4'(xc) : 4'd0;
        moves.o_valid  = ov;
        moves.o_cell   = ov ? 4'(oc) : 4'd0;
        #1;
        if (armed) begin
            check("x_ready", moves.x_ready,
                  m_on && !m_chk && m_whose == 0 && !s);
            check("o_ready", moves.o_ready,
                  m_on && !m_chk && m_whose == 1 && !s);
        end
        @(posedge clk);
        model_step(r, s, fp, xv, xv ? xc : 0, ov, ov ? oc : 0);
        #1;
        if (armed) begin
            check("board", board, exp_board());
            check("turn", turn, exp_turn());
            check("winner", winner, m_win);
            check("game_over", game_over, m_over);
            check("move_count", move_count, m_cnt);
            check("reject", reject, m_rej);
            check("reject_code", reject_code, m_rcode);
            check("timeout", timeout, m_tmo);
        end
    endtask

    task automatic play(input int xc, input int oc);
        cycle(0, 0, 0, xc, oc);
    endtask

    task automatic new_game(input bit fp);
        cycle(0, 1, fp, -1, -1);
    endtask

    initial begin
        int xs [5] = '{1, 3, 4, 8, 9};
        int os [4] = '{2, 5, 6, 7};
        armed = 0;
        rst = 1; start = 0; first_player = 0;
        moves.x_valid = 0; moves.x_cell = 0;
        moves.o_valid = 0; moves.o_cell = 0;
        cycle(1, 0, 0, -1, -1);
        cycle(1, 0, 0, -1, -1);
        check("rst_board", board, 18'd0);
        check("rst_turn", turn, 2'b00);

        new_game(0);
        check("s_turn", turn, 2'b01);
        check("s_board", board, 18'd0);
        play(1, -1); play(-1, -1);
        play(-1, 4); play(-1, -1);
        play(2, -1); play(-1, -1);
        play(-1, 5); play(-1, -1);
        play(3, -1);
        check("pre_chk_over", game_over, 1'b0);
        play(-1, -1);
        check("xwin_winner", winner, 2'b01);
        check("xwin_over", game_over, 1'b1);
        check("xwin_count", move_count, 4'd5);
        check("xwin_row", board[5:0], 6'b010101);
        play(7, 7);
        check("done_turn", turn, 2'b00);

        new_game(0);
        play(1, -1); play(-1, -1);
        play(-1, 1);
        check("occ_rej", reject, 1'b1);
        check("occ_code", reject_code, 2'b10);
        check("occ_turn", turn, 2'b10);
        check("occ_board", board, 18'b01);
        play(-1, 12);
        check("rng_code", reject_code, 2'b01);
        play(-1, -1);
        check("rej_pulse", reject, 1'b0);

        new_game(0);
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) play(xs[i/2], -1);
            else play(-1, os[i/2]);
            play(-1, -1);
        end
        check("draw_winner", winner, 2'b11);
        check("draw_count", move_count, 4'd9);

        new_game(0);
        for (int i = 0; i < TO; i++) play(-1, -1);
        check("to_pulse", timeout, 1'b1);
        check("to_turn", turn, 2'b10);
        check("to_count", move_count, 4'd0);
        new_game(0);
        for (int i = 0; i < TO - 1; i++) play(-1, -1);
        play(5, -1);
        check("to_hs_pulse", timeout, 1'b0);
        check("to_hs_count", move_count, 4'd1);

        new_game(0);
        play(1, -1); play(-1, -1);
        play(-1, 2); play(-1, -1);
        cycle(0, 1, 1, 5, -1);
        check("restart_board", board, 18'd0);
        check("restart_turn", turn, 2'b10);
        play(-1, 3); play(-1, -1);
        cycle(1, 1, 0, 4, -1);
        check("mid_rst_board", board, 18'd0);
        check("mid_rst_turn", turn, 2'b00);
        check("mid_rst_count", move_count, 4'd0);

        for (int n = 0; n < 4000; n++) begin
            bit r  = ($urandom_range(0, 299) == 0);
            bit s  = ($urandom_range(0, 59) == 0);
            int xc = -1;
            int oc = -1;
            if ($urandom_range(0, 9) < 6)
                xc = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 9)
                                                : $urandom_range(0, 15);
            if ($urandom_range(0, 9) < 6)
                oc = ($urandom_range(0, 9) < 8) ? $urandom_range(1, 9)
                                                : $urandom_range(0, 15);
            cycle(r, s, 1'($urandom_range(0, 1)), xc, oc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
